// File: rtl/mem_wb_stage_if.sv
// Purpose: MEM->WB handshake and payload bundle between the MEM stage and the WB stage.
// Latency: none; wires only.
// Backpressure: in_ready flows from WB back to MEM; MEM advances only while it is high.
interface mem_wb_stage_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [PC_W-1:0] in_pc;
    logic            in_wb_en;
    logic [4:0]      in_rd;
    logic [31:0]     in_alu_result;
    logic            in_is_load;
    logic [2:0]      in_load_type;
    logic [31:0]     in_mem_rdata;

    // MEM stage side
    modport master (
        output in_valid, in_pc, in_wb_en, in_rd, in_alu_result,
               in_is_load, in_load_type, in_mem_rdata,
        input  in_ready
    );

    // WB stage side
    modport slave (
        input  in_valid, in_pc, in_wb_en, in_rd, in_alu_result,
               in_is_load, in_load_type, in_mem_rdata,
        output in_ready
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Purpose: MEM->WB pipeline register, load-data formatter, regfile write / WB forwarding / retire drivers.
// Latency: 1 cycle MEM->WB; every output except in_ready comes straight from registered state.
// Backpressure: in_ready = !stall; a stalled entry holds and keeps forwarding but writes and retires once.
module mem_wb_stage #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    mem_wb_stage_if.slave    mem,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             fwd_valid,
    output logic [4:0]       fwd_addr,
    output logic [31:0]      fwd_data,
    output logic             retire_valid,
    output logic [PC_W-1:0]  retire_pc,
    output logic [CNT_W-1:0] retire_count
);
    localparam logic [2:0] LT_LB  = 3'd0;
    localparam logic [2:0] LT_LBU = 3'd1;
    localparam logic [2:0] LT_LH  = 3'd2;
    localparam logic [2:0] LT_LHU = 3'd3;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic            wb_en;
        logic [4:0]      rd;
        logic [31:0]     data;
        logic [PC_W-1:0] pc;
    } wb_entry_t;

    logic             valid;
    logic             done;     // entry has already spent its first cycle in WB
    wb_entry_t        ent;
    logic [CNT_W-1:0] retire_cnt;

    logic [1:0]       ea;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      fmt_data;
    logic             first;
    logic             writes_rd;

    // Writeback formatter: pick and extend the addressed byte/half of the little-endian word.
    always_comb begin
        ea       = mem.in_alu_result[1:0];
        ld_byte  = mem.in_mem_rdata[{ea, 3'b000} +: 8];
        ld_half  = ea[1] ? mem.in_mem_rdata[31:16] : mem.in_mem_rdata[15:0];
        fmt_data = mem.in_mem_rdata;
        if (!mem.in_is_load) begin
            fmt_data = mem.in_alu_result;
        end else begin
            case (mem.in_load_type)
                LT_LB:   fmt_data = {{24{ld_byte[7]}}, ld_byte};
                LT_LBU:  fmt_data = {24'h000000, ld_byte};
                LT_LH:   fmt_data = {{16{ld_half[15]}}, ld_half};
                LT_LHU:  fmt_data = {16'h0000, ld_half};
                default: fmt_data = mem.in_mem_rdata;
            endcase
        end
    end

    // Stage register: flush beats stall beats load; retire counter steps on every retirement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid      <= 1'b0;
            done       <= 1'b0;
            ent        <= '0;
            retire_cnt <= '0;
        end else begin
            if (retire_valid) begin
                retire_cnt <= retire_cnt + CNT_ONE;
            end
            if (flush) begin
                valid <= 1'b0;
                done  <= 1'b0;
            end else if (stall) begin
                done  <= valid;
            end else begin
                valid     <= mem.in_valid;
                done      <= 1'b0;
                ent.wb_en <= mem.in_wb_en;
                ent.rd    <= mem.in_rd;
                ent.pc    <= mem.in_pc;
                ent.data  <= fmt_data;
            end
        end
    end

    // Register-file writes and retirement happen only in the entry's first WB cycle;
    // forwarding stays up for as long as the entry is held. $0 is never written or forwarded.
    assign first        = valid & ~done;
    assign writes_rd    = ent.wb_en & (ent.rd != 5'd0);

    assign rf_we        = first & writes_rd;
    assign rf_waddr     = ent.rd;
    assign rf_wdata     = ent.data;

    assign fwd_valid    = valid & writes_rd;
    assign fwd_addr     = ent.rd;
    assign fwd_data     = ent.data;

    assign retire_valid = first;
    assign retire_pc    = ent.pc;
    assign retire_count = retire_cnt;

    // Ready is held low during reset so every output reads 0 while rst is asserted.
    assign mem.in_ready = rst & ~stall;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Purpose: randomized + directed bench for mem_wb_stage against a behavioural model.
// Latency: model advances once per rising edge; outputs sampled on the falling edge.
// Backpressure: stall/flush driven randomly and in directed sequences.
module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic [31:0] retire_count;

    mem_wb_stage_if #(.PC_W(32)) m_if ();

    mem_wb_stage #(.PC_W(32), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .mem          (m_if),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .fwd_valid    (fwd_valid),
        .fwd_addr     (fwd_addr),
        .fwd_data     (fwd_data),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model of what sits in WB: the entry plus how many cycles it has been there.
    logic        m_valid;
    int          m_age;
    logic        m_wb_en;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_fmt(input logic is_load, input logic [2:0] lt,
                                            input logic [31:0] addr, input logic [31:0] w);
        logic [31:0] v;
        int unsigned a;
        a = addr % 4;
        if (!is_load) return addr;
        if (lt == 3'd0 || lt == 3'd1) begin
            v = (w >> (8 * a)) & 32'hFF;
            if (lt == 3'd0 && v >= 32'd128) v = v + 32'hFFFFFF00;
            return v;
        end
        if (lt == 3'd2 || lt == 3'd3) begin
            v = (w >> (16 * (a / 2))) & 32'hFFFF;
            if (lt == 3'd2 && v >= 32'h8000) v = v + 32'hFFFF0000;
            return v;
        end
        return w;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_age = 0; m_wb_en = 1'b0; m_rd = '0;
        m_data = '0; m_pc = '0; m_cnt = '0;
    endtask

    task automatic model_step();
        if (m_valid && m_age == 0) m_cnt = m_cnt + 32'd1;
        if (flush) begin
            m_valid = 1'b0;
        end else if (stall) begin
            if (m_valid) m_age = m_age + 1;
        end else begin
            m_valid = m_if.in_valid;
            m_age   = 0;
            m_wb_en = m_if.in_wb_en;
            m_rd    = m_if.in_rd;
            m_pc    = m_if.in_pc;
            m_data  = ref_fmt(m_if.in_is_load, m_if.in_load_type, m_if.in_alu_result, m_if.in_mem_rdata);
        end
    endtask

    task automatic check_outputs();
        logic first;
        logic wr;
        first = m_valid && (m_age == 0);
        wr    = m_wb_en && (m_rd != 5'd0);
        check("rf_we",        rf_we,        first && wr);
        check("rf_waddr",     rf_waddr,     m_rd);
        check("rf_wdata",     rf_wdata,     m_data);
        check("fwd_valid",    fwd_valid,    m_valid && wr);
        check("fwd_addr",     fwd_addr,     m_rd);
        check("fwd_data",     fwd_data,     m_data);
        check("retire_valid", retire_valid, first);
        check("retire_pc",    retire_pc,    m_pc);
        check("retire_count", retire_count, m_cnt);
    endtask

    task automatic set_in(input logic v, input logic wb, input logic [4:0] rd, input logic ld,
                          input logic [2:0] lt, input logic [31:0] alu, input logic [31:0] rdata,
                          input logic [31:0] pc, input logic st, input logic fl);
        m_if.in_valid = v;   m_if.in_wb_en = wb;     m_if.in_rd = rd;
        m_if.in_is_load = ld; m_if.in_load_type = lt; m_if.in_alu_result = alu;
        m_if.in_mem_rdata = rdata; m_if.in_pc = pc;   stall = st; flush = fl;
    endtask

    task automatic idle_in();
        set_in(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // One clock: check ready, advance model at the edge, compare outputs on the falling edge.
    task automatic cycle();
        #1 check("in_ready", m_if.in_ready, !stall);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        int we_n;
        int fwd_n;
        logic [31:0] cnt0;

        rst = 1'b0;
        idle_in();
        model_reset();
        #1;
        check("rst_in_ready", m_if.in_ready, 1'b0);
        check_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Load formatting examples
        set_in(1, 1, 5'd4, 1, 3'd0, 32'h100, 32'h12345680, 32'h40, 0, 0); cycle();
        check("lb_a0",  rf_wdata, 32'hFFFFFF80);
        set_in(1, 1, 5'd4, 1, 3'd1, 32'h100, 32'h12345680, 32'h44, 0, 0); cycle();
        check("lbu_a0", rf_wdata, 32'h00000080);
        set_in(1, 1, 5'd4, 1, 3'd0, 32'h101, 32'h12345680, 32'h48, 0, 0); cycle();
        check("lb_a1",  rf_wdata, 32'h00000056);
        set_in(1, 1, 5'd5, 1, 3'd2, 32'h102, 32'h8001F00F, 32'h4C, 0, 0); cycle();
        check("lh_a2",  rf_wdata, 32'hFFFF8001);
        set_in(1, 1, 5'd5, 1, 3'd3, 32'h100, 32'h8001F00F, 32'h50, 0, 0); cycle();
        check("lhu_a0", rf_wdata, 32'h0000F00F);
        set_in(1, 1, 5'd5, 1, 3'd2, 32'h101, 32'h8001F00F, 32'h54, 0, 0); cycle();
        check("lh_a1",  rf_wdata, 32'hFFFFF00F);
        set_in(1, 1, 5'd6, 1, 3'd6, 32'h103, 32'hCAFEF00D, 32'h58, 0, 0); cycle();
        check("lw_t6",  rf_wdata, 32'hCAFEF00D);

        // ALU op held by a 3-cycle stall: one write, four forwarding cycles, one retirement
        we_n = 0; fwd_n = 0;
        set_in(1, 1, 5'd7, 0, 3'd0, 32'hDEADBEEF, 32'h0, 32'h60, 0, 0); cycle();
        cnt0 = retire_count;
        we_n += int'(rf_we); fwd_n += int'(fwd_valid);
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 5'd0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 1, 0); cycle();
            we_n += int'(rf_we); fwd_n += int'(fwd_valid);
        end
        idle_in(); cycle();
        we_n += int'(rf_we); fwd_n += int'(fwd_valid);
        check("stall_we_cycles",  we_n, 1);
        check("stall_fwd_cycles", fwd_n, 4);
        check("stall_cnt_delta",  retire_count - cnt0, 32'd1);

        // Write to $0 retires without writing or forwarding
        set_in(1, 1, 5'd0, 0, 3'd0, 32'h1234, 32'h0, 32'h70, 0, 0); cycle();
        check("r0_we", rf_we, 1'b0);
        check("r0_fwd", fwd_valid, 1'b0);
        check("r0_retire", retire_valid, 1'b1);

        // Flush and stall on the same edge: flush wins
        set_in(1, 1, 5'd3, 0, 3'd0, 32'h55, 32'h0, 32'h74, 0, 0); cycle();
        set_in(1, 1, 5'd9, 0, 3'd0, 32'h66, 32'h0, 32'h78, 1, 1); cycle();
        check("flst_retire", retire_valid, 1'b0);
        check("flst_fwd", fwd_valid, 1'b0);
        idle_in(); cycle();

        // Counter wrap from all-ones
        set_in(1, 1, 5'd8, 0, 3'd0, 32'h77, 32'h0, 32'h80, 0, 0); cycle();
        force dut.retire_cnt = 32'hFFFFFFFF;
        #1 release dut.retire_cnt;
        m_cnt = 32'hFFFFFFFF;
        check("wrap_pre", retire_count, 32'hFFFFFFFF);
        idle_in(); cycle();
        check("wrap_post", retire_count, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom % 10) < 7, $urandom % 2, (($urandom % 8) == 0) ? 5'd0 : 5'($urandom),
                   $urandom % 2, 3'($urandom), $urandom, $urandom, $urandom,
                   ($urandom % 4) == 0, ($urandom % 10) == 0);
            cycle();
        end

        // Reset mid-stream while a fresh entry is in its first WB cycle
        set_in(1, 1, 5'd9, 0, 3'd0, 32'hA5A5A5A5, 32'h0, 32'h90, 0, 0); cycle();
        check("pre_rst_we", rf_we, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_rst_we", rf_we, 1'b0);
        check("mid_rst_fwd", fwd_valid, 1'b0);
        check("mid_rst_cnt", retire_count, 32'd0);
        check("mid_rst_retire", retire_valid, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b1;
        idle_in();
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
